add_feeder: RTL

ADD_FEEDER -- requirements
Module: add_feeder

---
 rtl/add_feeder.sv | 100 ++++++++++
 1 files changed

// File: rtl/add_feeder.sv
// Operand-pair FIFO that feeds an external adder and registers its sum.
// The adder sits outside the block: op_a/op_b go out and add_y comes back combinationally.
module add_feeder #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic [W-1:0]             op_a,
  output logic [W-1:0]             op_b,
  input  logic [W:0]               add_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W:0]               out_y,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  a_mem [DEPTH];
  logic [W-1:0]  b_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          out_valid_q, out_valid_d;
  logic [W:0]    out_y_q,     out_y_d;

  logic push, pop, fifo_empty;

  assign fifo_empty = (count_q == '0);
  // Readiness comes from occupancy alone, so a full FIFO never passes through on out_ready.
  assign in_ready   = (count_q < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (!out_valid_q || out_ready);

  assign op_a      = fifo_empty ? '0 : a_mem[rd_ptr_q];
  assign op_b      = fifo_empty ? '0 : b_mem[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign count     = count_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: ;
    endcase

    if (pop) begin
      out_y_d     = add_y;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q] <= in_a;
      b_mem[wr_ptr_q] <= in_b;
    end
  end

endmodule
